clock_monitor: RTL and testbench

//  Receiving end of a buffered clock. Samples a distributed clock (mon_clk) as

---
 rtl/clock_monitor_pkg.sv | 16 +
 rtl/clk_sync_edge.sv | 29 ++
 rtl/clock_monitor.sv | 167 ++++++++++++++++
 tb/tb_clock_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types and fault encodings for the clock monitor.
package clock_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_MEASURE,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_LOST = 2'b01;
  localparam logic [1:0] FC_FAST = 2'b10;

endpackage : clock_monitor_pkg

// File: rtl/clk_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a rising-edge pulse
// taken from the synchronized output.
module clk_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: flops are written with <= so every stage samples the pre-edge value
  // of its neighbour; blocking assignments would collapse the chain to one flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : clk_sync_edge

// File: rtl/clock_monitor.sv
// Measures the period of an asynchronous monitored clock in clk_in cycles,
// declares lock after enough in-range periods and latches loss/too-fast faults.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int MIN_PERIOD  = 4,
  parameter  int MAX_PERIOD  = 64,
  parameter  int LOCK_COUNT  = 4,
  localparam int CNT_W       = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_P  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_M1 = CNT_W'(MAX_PERIOD - 1);
  localparam logic [GOOD_W-1:0] LOCK_G = GOOD_W'(LOCK_COUNT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                pv_q, pv_d;
  logic [1:0]          code_q, code_d;

  logic                mon_edge;
  logic                timeout;
  logic                in_range;
  logic [CNT_W-1:0]    meas;
  logic [GOOD_W-1:0]   good_inc;

  clk_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (mon_clk),
    .edge_o   (mon_edge)
  );

  // The period ending on this edge includes the edge cycle itself.
  assign meas     = cnt_q + 1'b1;
  assign good_inc = good_q + 1'b1;
  assign timeout  = !mon_edge && (cnt_q == MAX_M1);
  assign in_range = (meas >= MIN_P) && (meas <= MAX_P);

  // NOTE: every variable gets a default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    code_d   = code_q;

    if (mon_edge) begin
      cnt_d = '0;
    end else if (cnt_q == MAX_P) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      good_d   = '0;
      period_d = '0;
      code_d   = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
          good_d  = '0;
        end
        ST_ACQUIRE: begin
          // The first edge only establishes phase; no period is known yet.
          if (mon_edge) begin
            state_d = ST_MEASURE;
            good_d  = '0;
          end else if (timeout) begin
            state_d = ST_FAULT;
            code_d  = FC_LOST;
          end
        end
        ST_MEASURE: begin
          if (mon_edge) begin
            pv_d     = 1'b1;
            period_d = meas;
            if (!in_range) begin
              good_d = '0;
            end else if (good_inc == LOCK_G) begin
              good_d  = good_inc;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_inc;
            end
          end else if (timeout) begin
            state_d = ST_FAULT;
            code_d  = FC_LOST;
          end
        end
        ST_LOCKED: begin
          if (mon_edge) begin
            pv_d     = 1'b1;
            period_d = meas;
            if (meas < MIN_P) begin
              state_d = ST_FAULT;
              code_d  = FC_FAST;
            end
          end else if (timeout) begin
            state_d = ST_FAULT;
            code_d  = FC_LOST;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
            code_d  = FC_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      code_q   <= code_d;
    end
  end

  assign period_o     = period_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == ST_LOCKED);
  assign fault        = (state_q == ST_FAULT);
  assign fault_code   = code_q;

endmodule : clock_monitor

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: lock, loss, too-fast, period limits,
// enable override and asynchronous reset.
module tb_clock_monitor;

  localparam int CNT_W = 7;

  logic             clk_in;
  logic             rst_n;
  logic             mon_clk;
  logic             enable;
  logic             clear_fault;
  logic [CNT_W-1:0] period_o;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;

  int errors = 0;
  int checks = 0;
  int mon_half = 0;

  clock_monitor #(
    .SYNC_STAGES (2),
    .MIN_PERIOD  (4),
    .MAX_PERIOD  (64),
    .LOCK_COUNT  (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .mon_clk      (mon_clk),
    .enable       (enable),
    .clear_fault  (clear_fault),
    .period_o     (period_o),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Monitored clock: a new half period is picked up only at a rising edge,
  // and rising edges always fall 2 ns past a multiple of 10 ns.
  initial begin : mon_gen
    int h;
    mon_clk = 1'b0;
    #2;
    forever begin
      if (mon_half == 0) begin
        #10;
      end else begin
        h = mon_half;
        mon_clk = 1'b1;
        #(h);
        mon_clk = 1'b0;
        #(h);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pv(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!period_valid && n < budget);
  endtask

  task automatic wait_fault(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!fault && n < budget);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_period"}, period_o, 0);
    check({tag, "_pv"}, period_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
  endtask

  initial begin : stim
    int n;
    int rises;
    logic prev;

    rst_n = 1'b0;
    enable = 1'b0;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk_in);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk_in);

    // Disable in MEASURE after the first measured period.
    enable = 1'b1;
    mon_half = 50;
    wait_pv(40, n);
    check("meas_pv", period_valid, 1);
    check("meas_period", period_o, 10);
    check("meas_locked", locked, 0);
    enable = 1'b0;
    @(negedge clk_in);
    check_idle("dis_meas");

    // Lock at 100 ns: four measured periods after the acquiring edge.
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_pv(40, n);
      check("t1_pv", period_valid, 1);
      check("t1_period", period_o, 10);
      check("t1_locked", locked, (i == 4));
      check("t1_fault", fault, 0);
    end

    // Stop the clock: loss fault 64 cycles after the last period pulse.
    mon_half = 0;
    wait_fault(200, n);
    check("t2_delay", n, 64);
    check("t2_fault", fault, 1);
    check("t2_code", fault_code, 1);
    check("t2_locked", locked, 0);
    mon_half = 50;
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
    check("t2_clr_fault", fault, 0);
    check("t2_clr_code", fault_code, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_pv(40, n);
      check("t2_period", period_o, 10);
      check("t2_relock", locked, (i == 4));
    end

    // Too fast: 30 ns period while locked.
    mon_half = 15;
    wait_pv(40, n);
    check("t3_period_a", period_o, 10);
    check("t3_locked_a", locked, 1);
    wait_pv(20, n);
    check("t3_pv", period_valid, 1);
    check("t3_period_b", period_o, 3);
    check("t3_fault", fault, 1);
    check("t3_code", fault_code, 2);
    check("t3_locked_b", locked, 0);

    // Disable while in FAULT.
    enable = 1'b0;
    @(negedge clk_in);
    check_idle("dis_fault");

    // Boundary periods: 4 locks, 64 accepted, 65 times out.
    mon_half = 0;
    repeat (20) @(negedge clk_in);
    mon_half = 20;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_pv(40, n);
      check("t4_period4", period_o, 4);
      check("t4_lock4", locked, (i == 4));
    end
    mon_half = 320;
    wait_pv(40, n);
    check("t4_tail4", period_o, 4);
    wait_pv(100, n);
    check("t4_period64", period_o, 64);
    check("t4_lock64", locked, 1);
    mon_half = 325;
    wait_pv(100, n);
    check("t4_tail64", period_o, 64);
    wait_fault(100, n);
    check("t4_65_delay", n, 64);
    check("t4_65_fault", fault, 1);
    check("t4_65_code", fault_code, 1);

    // Acquire lock from scratch at exactly 64 cycles.
    mon_half = 0;
    repeat (80) @(negedge clk_in);
    mon_half = 320;
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_pv(100, n);
      check("t4_acq64", period_o, 64);
      check("t4_acq64_lock", locked, (i == 4));
    end

    // Asynchronous reset pulse while locked.
    mon_half = 50;
    wait_pv(100, n);
    check("t6_tail", period_o, 64);
    wait_pv(40, n);
    check("t6_period", period_o, 10);
    check("t6_locked", locked, 1);
    @(negedge mon_clk);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1 check_idle("t6_rst");
    #2 rst_n = 1'b1;
    prev = mon_clk;
    rises = 0;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (mon_clk && !prev) rises++;
      prev = mon_clk;
    end while (!period_valid && n < 60);
    check("t6_pv", period_valid, 1);
    check("t6_rises", rises, 2);
    check("t6_period_after", period_o, 10);
    check("t6_locked_after", locked, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clock_monitor
